// File: rtl/sync_link_if.sv
// Signal bundle between the link controller, management and the synchronizer.
// lost_sync_count is present only when SYNC_LINK_CTRL_STATS_EN is defined.
interface sync_link_if #(
  parameter int RETRY_W = 4
);
  logic               link_enable;
  logic               code_sync_status;
  logic               sync_rst_n;
  logic               link_up;
  logic               link_fail;
  logic [RETRY_W-1:0] retry_count;
  logic [2:0]         state;
`ifdef SYNC_LINK_CTRL_STATS_EN
  logic [7:0]         lost_sync_count;
`endif

  modport master (
    input  link_enable,
    input  code_sync_status,
`ifdef SYNC_LINK_CTRL_STATS_EN
    output lost_sync_count,
`endif
    output sync_rst_n,
    output link_up,
    output link_fail,
    output retry_count,
    output state
  );

  modport slave (
    output link_enable,
    output code_sync_status,
`ifdef SYNC_LINK_CTRL_STATS_EN
    input  lost_sync_count,
`endif
    input  sync_rst_n,
    input  link_up,
    input  link_fail,
    input  retry_count,
    input  state
  );
endinterface

// File: rtl/sync_link_ctrl.sv
// Link bring-up controller: resets and times the code-group synchronizer.
// Optional loss statistics via the SYNC_LINK_CTRL_STATS_EN macro.
module sync_link_ctrl #(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STABLE_CYCLES  = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 8,
  parameter int RETRY_W        = 4
) (
  input  logic        sync_clk,
  input  logic        mr_main_reset,
  sync_link_if.master lnk
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_WAIT  = 3'd2,
    S_QUAL  = 3'd3,
    S_UP    = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_RST_END =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO_END =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STABLE =
    CNT_W'(STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] L_MAX_RT =
    RETRY_W'(MAX_RETRIES);

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nx;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nx;
  logic               r_rst_n;
  logic               r_up;
  logic               r_fail;
  logic               w_rst_n_nx;
  logic               w_up_nx;
  logic               w_fail_nx;
  logic               w_cs;

  assign w_cs = lnk.code_sync_status;

  always_ff @(posedge sync_clk) begin
    if (mr_main_reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_retry <= '0;
      r_rst_n <= 1'b0;
      r_up    <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_retry <= w_retry_nx;
      r_rst_n <= w_rst_n_nx;
      r_up    <= w_up_nx;
      r_fail  <= w_fail_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_retry_nx = r_retry;
    if (!lnk.link_enable) begin
      w_state_nx = S_IDLE;
      w_timer_nx = '0;
      w_retry_nx = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nx = S_RESET;
          w_timer_nx = '0;
        end
        S_RESET: begin
          if (r_timer >= L_RST_END) begin
            w_state_nx = S_WAIT;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_cs) begin
            w_state_nx = S_QUAL;
            w_timer_nx = '0;
          end else if (r_timer >= L_TO_END) begin
            w_timer_nx = '0;
            if (r_retry < L_MAX_RT) begin
              w_retry_nx = r_retry + 1'b1;
              w_state_nx = S_RESET;
            end else begin
              w_state_nx = S_FAIL;
            end
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
        S_QUAL: begin
          // Drop-out returns to hunting without spending a retry.
          if (!w_cs) begin
            w_state_nx = S_WAIT;
            w_timer_nx = '0;
          end else if (r_timer >= L_STABLE) begin
            w_state_nx = S_UP;
            w_timer_nx = '0;
            w_retry_nx = '0;
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
        S_UP: begin
          w_retry_nx = '0;
          if (!w_cs) begin
            w_state_nx = S_WAIT;
            w_timer_nx = '0;
          end
        end
        S_FAIL: begin
          w_timer_nx = '0;
        end
        default: begin
          w_state_nx = S_IDLE;
          w_timer_nx = '0;
          w_retry_nx = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    w_rst_n_nx = 1'b0;
    w_up_nx    = 1'b0;
    w_fail_nx  = 1'b0;
    unique case (w_state_nx)
      S_WAIT:  w_rst_n_nx = 1'b1;
      S_QUAL:  w_rst_n_nx = 1'b1;
      S_UP: begin
        w_rst_n_nx = 1'b1;
        w_up_nx    = 1'b1;
      end
      S_FAIL:  w_fail_nx  = 1'b1;
      default: w_rst_n_nx = 1'b0;
    endcase
  end

  assign lnk.sync_rst_n  = r_rst_n;
  assign lnk.link_up     = r_up;
  assign lnk.link_fail   = r_fail;
  assign lnk.retry_count = r_retry;
  assign lnk.state       = r_state;

`ifdef SYNC_LINK_CTRL_STATS_EN
  logic [7:0] r_lost;
  logic       w_lost_ev;

  assign w_lost_ev = (r_state == S_UP) &&
                     (w_state_nx == S_WAIT);

  always_ff @(posedge sync_clk) begin
    if (mr_main_reset) begin
      r_lost <= '0;
    end else if (w_lost_ev && (r_lost != 8'hFF)) begin
      r_lost <= r_lost + 8'd1;
    end
  end

  assign lnk.lost_sync_count = r_lost;
`endif

endmodule
